// File: rtl/dir_req_arbiter_pkg.sv
// Shared parameters and types for the directory request arbiter.
`default_nettype none

package dir_req_arbiter_pkg;

    localparam int N_CPUS            = 4;
    localparam int MSHR_SIZE         = 1;
    localparam int FULL_ADDRESS_BITS = 32;
    localparam int BYTE_OFFSET_BITS  = 4;
    localparam int INDEX_BITS        = 6;
    localparam int TAG_BITS          = FULL_ADDRESS_BITS - INDEX_BITS - BYTE_OFFSET_BITS;
    localparam int CPU_ID_BITS       = (N_CPUS > 1) ? $clog2(N_CPUS) : 1;
    localparam int MSHR_ID_BITS      = (MSHR_SIZE > 1) ? $clog2(MSHR_SIZE) : 1;
    localparam int OT_DEPTH          = N_CPUS * MSHR_SIZE;
    localparam int LINE_BITS         = TAG_BITS + INDEX_BITS;

    typedef logic [LINE_BITS-1:0] line_addr_t;

    typedef enum logic {
        CPU_READ  = 1'b0,
        CPU_WRITE = 1'b1
    } cpu_request_type_t;

    typedef struct packed {
        logic [CPU_ID_BITS-1:0]  cpu_id;
        logic [MSHR_ID_BITS-1:0] mshr_id;
    } req_id_t;

    typedef struct packed {
        logic       valid;
        line_addr_t line;
        req_id_t    id;
    } ot_entry_t;

    typedef enum logic [0:0] {
        ARB_IDLE  = 1'b0,
        ARB_ISSUE = 1'b1
    } arb_state_t;

    function automatic line_addr_t line_of(input logic [FULL_ADDRESS_BITS-1:0] addr);
        return addr[FULL_ADDRESS_BITS-1:BYTE_OFFSET_BITS];
    endfunction

endpackage

`default_nettype wire

// File: rtl/dir_req_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first eligible requester after ptr_i, wrapping.
`default_nettype none

module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     elig_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N-1:0]     grant_o,
    output logic [IDX_W-1:0] grant_idx_o,
    output logic             any_o
);

    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        any_o       = 1'b0;
        for (int k = 1; k <= N; k++) begin
            if (!any_o && elig_i[(int'(ptr_i) + k) % N]) begin
                any_o                          = 1'b1;
                grant_o[(int'(ptr_i) + k) % N] = 1'b1;
                grant_idx_o                    = IDX_W'((int'(ptr_i) + k) % N);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/dir_req_arbiter.sv
// Round-robin arbiter onto the directory request port with an outstanding-line
// table that blocks requests to lines already in flight.
`default_nettype none

module dir_req_arbiter
    import dir_req_arbiter_pkg::*;
(
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic [N_CPUS-1:0]                           req_valid_i,
    output logic [N_CPUS-1:0]                           req_ready_o,
    input  logic [N_CPUS-1:0][FULL_ADDRESS_BITS-1:0]    req_addr_i,
    input  cpu_request_type_t [N_CPUS-1:0]              req_type_i,
    input  logic [N_CPUS-1:0][MSHR_ID_BITS-1:0]         req_mshr_i,
    output logic                                        dir_valid_o,
    input  logic                                        dir_ready_i,
    output logic [FULL_ADDRESS_BITS-1:0]                dir_addr_o,
    output cpu_request_type_t                           dir_type_o,
    output req_id_t                                     dir_id_o,
    input  logic                                        done_valid_i,
    input  req_id_t                                     done_id_i,
    output logic                                        ot_full_o,
    output logic                                        err_o
);

    localparam int SLOT_W = (OT_DEPTH > 1) ? $clog2(OT_DEPTH) : 1;

    arb_state_t                     state_q, state_d;
    logic [CPU_ID_BITS-1:0]         rr_ptr_q, rr_ptr_d;
    ot_entry_t [OT_DEPTH-1:0]       ot_q, ot_d;
    logic                           dir_valid_q, dir_valid_d;
    logic [FULL_ADDRESS_BITS-1:0]   dir_addr_q, dir_addr_d;
    cpu_request_type_t              dir_type_q, dir_type_d;
    req_id_t                        dir_id_q, dir_id_d;
    logic                           ot_full_q, ot_full_d;
    logic                           err_q, err_d;

    logic [OT_DEPTH-1:0]            valid_vec;
    logic [OT_DEPTH-1:0]            valid_next;
    logic                           table_full;
    logic [N_CPUS-1:0]              line_hit;
    logic [N_CPUS-1:0]              elig;
    logic [N_CPUS-1:0]              grant;
    logic [CPU_ID_BITS-1:0]         grant_idx;
    logic                           grant_any;
    logic                           accept;
    logic                           free_found;
    logic [SLOT_W-1:0]              free_idx;
    logic [OT_DEPTH-1:0]            done_hit;

    always_comb begin
        valid_vec = '0;
        for (int e = 0; e < OT_DEPTH; e++) begin
            valid_vec[e] = ot_q[e].valid;
        end
    end

    assign table_full = &valid_vec;

    // Eligibility and slot choice use pre-release state, so a line or slot
    // being freed this cycle only becomes usable on the next one.
    always_comb begin
        line_hit = '0;
        for (int i = 0; i < N_CPUS; i++) begin
            for (int e = 0; e < OT_DEPTH; e++) begin
                if (ot_q[e].valid && (ot_q[e].line == line_of(req_addr_i[i]))) begin
                    line_hit[i] = 1'b1;
                end
            end
        end
    end

    assign elig = req_valid_i & ~line_hit & {N_CPUS{~table_full}};

    rr_arbiter #(
        .N     (N_CPUS),
        .IDX_W (CPU_ID_BITS)
    ) u_rr (
        .elig_i      (elig),
        .ptr_i       (rr_ptr_q),
        .grant_o     (grant),
        .grant_idx_o (grant_idx),
        .any_o       (grant_any)
    );

    assign accept      = (state_q == ARB_IDLE) && grant_any && !rst;
    assign req_ready_o = accept ? grant : '0;

    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int e = 0; e < OT_DEPTH; e++) begin
            if (!free_found && !ot_q[e].valid) begin
                free_found = 1'b1;
                free_idx   = SLOT_W'(e);
            end
        end
    end

    always_comb begin
        done_hit = '0;
        for (int e = 0; e < OT_DEPTH; e++) begin
            done_hit[e] = done_valid_i && ot_q[e].valid && (ot_q[e].id == done_id_i);
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        ot_d        = ot_q;
        dir_valid_d = dir_valid_q;
        dir_addr_d  = dir_addr_q;
        dir_type_d  = dir_type_q;
        dir_id_d    = dir_id_q;
        err_d       = err_q;

        for (int e = 0; e < OT_DEPTH; e++) begin
            if (done_hit[e]) begin
                ot_d[e].valid = 1'b0;
            end
        end
        if (done_valid_i && (done_hit == '0)) begin
            err_d = 1'b1;
        end

        case (state_q)
            ARB_IDLE: begin
                if (accept && free_found) begin
                    dir_addr_d         = {line_of(req_addr_i[grant_idx]), {BYTE_OFFSET_BITS{1'b0}}};
                    dir_type_d         = req_type_i[grant_idx];
                    dir_id_d.cpu_id    = grant_idx;
                    dir_id_d.mshr_id   = req_mshr_i[grant_idx];
                    dir_valid_d        = 1'b1;
                    ot_d[free_idx].valid = 1'b1;
                    ot_d[free_idx].line  = line_of(req_addr_i[grant_idx]);
                    ot_d[free_idx].id    = dir_id_d;
                    rr_ptr_d           = grant_idx;
                    state_d            = ARB_ISSUE;
                end
            end
            ARB_ISSUE: begin
                if (dir_ready_i) begin
                    dir_valid_d = 1'b0;
                    state_d     = ARB_IDLE;
                end
            end
            default: begin
                state_d     = ARB_IDLE;
                dir_valid_d = 1'b0;
            end
        endcase
    end

    always_comb begin
        valid_next = '0;
        for (int e = 0; e < OT_DEPTH; e++) begin
            valid_next[e] = ot_d[e].valid;
        end
    end

    assign ot_full_d = &valid_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ARB_IDLE;
            rr_ptr_q    <= CPU_ID_BITS'(N_CPUS - 1);
            ot_q        <= '0;
            dir_valid_q <= 1'b0;
            dir_addr_q  <= '0;
            dir_type_q  <= CPU_READ;
            dir_id_q    <= '0;
            ot_full_q   <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            ot_q        <= ot_d;
            dir_valid_q <= dir_valid_d;
            dir_addr_q  <= dir_addr_d;
            dir_type_q  <= dir_type_d;
            dir_id_q    <= dir_id_d;
            ot_full_q   <= ot_full_d;
            err_q       <= err_d;
        end
    end

    assign dir_valid_o = dir_valid_q;
    assign dir_addr_o  = dir_addr_q;
    assign dir_type_o  = dir_type_q;
    assign dir_id_o    = dir_id_q;
    assign ot_full_o   = ot_full_q;
    assign err_o       = err_q;

endmodule

`default_nettype wire

// File: tb/tb_dir_req_arbiter.sv
// Directed bench for dir_req_arbiter: a per-cycle vector table plus short sequences.
`default_nettype none

module tb_dir_req_arbiter;
    import dir_req_arbiter_pkg::*;

    logic                                      clk = 1'b0;
    logic                                      rst;
    logic [N_CPUS-1:0]                         req_valid_i;
    logic [N_CPUS-1:0]                         req_ready_o;
    logic [N_CPUS-1:0][FULL_ADDRESS_BITS-1:0]  req_addr_i;
    cpu_request_type_t [N_CPUS-1:0]            req_type_i;
    logic [N_CPUS-1:0][MSHR_ID_BITS-1:0]       req_mshr_i;
    logic                                      dir_valid_o;
    logic                                      dir_ready_i;
    logic [FULL_ADDRESS_BITS-1:0]              dir_addr_o;
    cpu_request_type_t                         dir_type_o;
    req_id_t                                   dir_id_o;
    logic                                      done_valid_i;
    req_id_t                                   done_id_i;
    logic                                      ot_full_o;
    logic                                      err_o;

    int n_tests = 0;
    int n_fail  = 0;

    dir_req_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_addr_i   (req_addr_i),
        .req_type_i   (req_type_i),
        .req_mshr_i   (req_mshr_i),
        .dir_valid_o  (dir_valid_o),
        .dir_ready_i  (dir_ready_i),
        .dir_addr_o   (dir_addr_o),
        .dir_type_o   (dir_type_o),
        .dir_id_o     (dir_id_o),
        .done_valid_i (done_valid_i),
        .done_id_i    (done_id_i),
        .ot_full_o    (ot_full_o),
        .err_o        (err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]       valid;
        logic [3:0][31:0] addr;
        logic [3:0]       wr;
        logic             rdy;
        logic             dv;
        logic [2:0]       did;
        logic [3:0]       e_ready;
        logic             e_dvalid;
        logic [31:0]      e_addr;
        logic             e_type;
        logic [2:0]       e_id;
        logic             e_full;
        logic             e_err;
    } vec_t;

    vec_t vecs [11];

    function automatic vec_t mk(input logic [3:0] valid, input logic [127:0] addr,
                                input logic [3:0] wr, input logic rdy, input logic dv,
                                input logic [2:0] did, input logic [3:0] e_ready,
                                input logic e_dvalid, input logic [31:0] e_addr,
                                input logic e_type, input logic [2:0] e_id,
                                input logic e_full, input logic e_err);
        vec_t v;
        v.valid = valid;  v.addr = addr;  v.wr = wr;  v.rdy = rdy;  v.dv = dv;  v.did = did;
        v.e_ready = e_ready;  v.e_dvalid = e_dvalid;  v.e_addr = e_addr;  v.e_type = e_type;
        v.e_id = e_id;  v.e_full = e_full;  v.e_err = e_err;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        req_valid_i  = '0;
        req_addr_i   = '0;
        req_mshr_i   = '0;
        dir_ready_i  = 1'b0;
        done_valid_i = 1'b0;
        done_id_i    = '0;
        for (int i = 0; i < N_CPUS; i++) req_type_i[i] = CPU_READ;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        clear_inputs();
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Single request (CPU2), then a same-line conflict between CPU0 and CPU1.
        vecs[0]  = mk(4'b0000, 128'h0, 4'b0000, 0, 0, 3'd0, 4'b0000, 0, 32'h0,   0, 3'd0, 0, 0);
        vecs[1]  = mk(4'b0100, {32'h0, 32'h100, 32'h0, 32'h0}, 4'b0000, 0, 0, 3'd0,
                      4'b0100, 0, 32'h0,   0, 3'd0, 0, 0);
        vecs[2]  = mk(4'b0000, 128'h0, 4'b0000, 1, 0, 3'd0, 4'b0000, 1, 32'h100, 0, 3'd4, 0, 0);
        vecs[3]  = mk(4'b0000, 128'h0, 4'b0000, 0, 1, 3'd4, 4'b0000, 0, 32'h100, 0, 3'd4, 0, 0);
        vecs[4]  = mk(4'b0001, {32'h0, 32'h0, 32'h0, 32'h200}, 4'b0000, 0, 0, 3'd0,
                      4'b0001, 0, 32'h100, 0, 3'd4, 0, 0);
        vecs[5]  = mk(4'b0010, {32'h0, 32'h0, 32'h20C, 32'h0}, 4'b0010, 1, 0, 3'd0,
                      4'b0000, 1, 32'h200, 0, 3'd0, 0, 0);
        vecs[6]  = mk(4'b0010, {32'h0, 32'h0, 32'h20C, 32'h0}, 4'b0010, 0, 0, 3'd0,
                      4'b0000, 0, 32'h200, 0, 3'd0, 0, 0);
        vecs[7]  = mk(4'b0010, {32'h0, 32'h0, 32'h20C, 32'h0}, 4'b0010, 0, 1, 3'd0,
                      4'b0000, 0, 32'h200, 0, 3'd0, 0, 0);
        vecs[8]  = mk(4'b0010, {32'h0, 32'h0, 32'h20C, 32'h0}, 4'b0010, 0, 0, 3'd0,
                      4'b0010, 0, 32'h200, 0, 3'd0, 0, 0);
        vecs[9]  = mk(4'b0000, 128'h0, 4'b0000, 1, 0, 3'd0, 4'b0000, 1, 32'h200, 1, 3'd2, 0, 0);
        vecs[10] = mk(4'b0000, 128'h0, 4'b0000, 0, 1, 3'd2, 4'b0000, 0, 32'h200, 1, 3'd2, 0, 0);

        do_reset();
        for (int v = 0; v < 11; v++) begin
            req_valid_i  = vecs[v].valid;
            req_addr_i   = vecs[v].addr;
            for (int i = 0; i < N_CPUS; i++) req_type_i[i] = vecs[v].wr[i] ? CPU_WRITE : CPU_READ;
            dir_ready_i  = vecs[v].rdy;
            done_valid_i = vecs[v].dv;
            done_id_i    = req_id_t'(vecs[v].did);
            @(negedge clk);
            check($sformatf("v%0d req_ready", v), 64'(req_ready_o), 64'(vecs[v].e_ready));
            check($sformatf("v%0d dir_valid", v), 64'(dir_valid_o), 64'(vecs[v].e_dvalid));
            check($sformatf("v%0d dir_addr", v),  64'(dir_addr_o),  64'(vecs[v].e_addr));
            check($sformatf("v%0d dir_type", v),  64'(dir_type_o),  64'(vecs[v].e_type));
            check($sformatf("v%0d dir_id", v),    64'(dir_id_o),    64'(vecs[v].e_id));
            check($sformatf("v%0d ot_full", v),   64'(ot_full_o),   64'(vecs[v].e_full));
            check($sformatf("v%0d err", v),       64'(err_o),       64'(vecs[v].e_err));
            tick();
        end

        // Fairness: all four valid on distinct lines, completions returned at issue.
        do_reset();
        req_valid_i = 4'b1111;
        for (int i = 0; i < N_CPUS; i++) req_addr_i[i] = 32'h1000 + 32'(i) * 32'h40;
        dir_ready_i = 1'b1;
        for (int k = 0; k < 5; k++) begin
            logic [1:0] w;
            w = 2'(k % 4);
            done_valid_i = 1'b0;
            @(negedge clk);
            check($sformatf("fair%0d grant", k), 64'(req_ready_o), 64'(4'b0001 << w));
            tick();
            done_valid_i = 1'b1;
            done_id_i    = req_id_t'({w, 1'b0});
            @(negedge clk);
            check($sformatf("fair%0d dir_valid", k), 64'(dir_valid_o), 64'd1);
            check($sformatf("fair%0d dir_id", k),    64'(dir_id_o),    64'({w, 1'b0}));
            tick();
        end

        // Back-pressure: issue held stable for 10 cycles, next grant once released.
        do_reset();
        req_valid_i   = 4'b0101;
        req_addr_i[0] = 32'h300;
        req_addr_i[2] = 32'h404;
        @(negedge clk);
        check("bp first grant", 64'(req_ready_o), 64'(4'b0001));
        tick();
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check($sformatf("bp%0d dir_valid", c), 64'(dir_valid_o), 64'd1);
            check($sformatf("bp%0d dir_addr", c),  64'(dir_addr_o),  64'h300);
            check($sformatf("bp%0d req_ready", c), 64'(req_ready_o), 64'd0);
            tick();
        end
        dir_ready_i = 1'b1;
        @(negedge clk);
        check("bp handshake dir_valid", 64'(dir_valid_o), 64'd1);
        tick();
        dir_ready_i = 1'b0;
        req_valid_i = 4'b0100;
        @(negedge clk);
        check("bp second grant", 64'(req_ready_o), 64'(4'b0100));
        check("bp idle dir_valid", 64'(dir_valid_o), 64'd0);
        tick();
        @(negedge clk);
        check("bp second addr", 64'(dir_addr_o), 64'h400);
        tick();

        // Full table: four outstanding, a fifth stalls until a completion frees slot 1.
        do_reset();
        req_valid_i = 4'b1111;
        for (int i = 0; i < N_CPUS; i++) req_addr_i[i] = 32'h2000 + 32'(i) * 32'h100;
        dir_ready_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("full%0d grant", k), 64'(req_ready_o), 64'(4'b0001 << k));
            tick();
            @(negedge clk);
            check($sformatf("full%0d ot_full", k), 64'(ot_full_o), 64'(k == 3));
            tick();
        end
        req_addr_i[1] = 32'h5000;
        @(negedge clk);
        check("full stall ready", 64'(req_ready_o), 64'd0);
        check("full stall ot_full", 64'(ot_full_o), 64'd1);
        tick();
        done_valid_i = 1'b1;
        done_id_i    = req_id_t'(3'b010);
        @(negedge clk);
        check("full release-cycle ready", 64'(req_ready_o), 64'd0);
        tick();
        done_valid_i = 1'b0;
        @(negedge clk);
        check("full after release ready", 64'(req_ready_o), 64'(4'b0010));
        check("full after release ot_full", 64'(ot_full_o), 64'd0);
        tick();
        @(negedge clk);
        check("full refill dir_addr", 64'(dir_addr_o), 64'h5000);
        check("full refill dir_id", 64'(dir_id_o), 64'(3'b010));
        check("full refill ot_full", 64'(ot_full_o), 64'd1);
        check("full err", 64'(err_o), 64'd0);
        tick();

        // Bogus completion sets sticky err; reset mid-issue clears everything.
        do_reset();
        done_valid_i = 1'b1;
        done_id_i    = req_id_t'(3'b110);
        @(negedge clk);
        check("err before", 64'(err_o), 64'd0);
        tick();
        done_valid_i = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("err sticky%0d", c), 64'(err_o), 64'd1);
            tick();
        end
        req_valid_i   = 4'b0001;
        req_addr_i[0] = 32'h600;
        req_type_i[0] = CPU_WRITE;
        @(negedge clk);
        check("rst-case grant", 64'(req_ready_o), 64'(4'b0001));
        tick();
        req_valid_i = 4'b0000;
        @(negedge clk);
        check("rst-case issuing", 64'(dir_valid_o), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("post-rst dir_valid", 64'(dir_valid_o), 64'd0);
        check("post-rst dir_addr",  64'(dir_addr_o),  64'd0);
        check("post-rst dir_id",    64'(dir_id_o),    64'd0);
        check("post-rst dir_type",  64'(dir_type_o),  64'd0);
        check("post-rst err",       64'(err_o),       64'd0);
        check("post-rst ot_full",   64'(ot_full_o),   64'd0);
        check("post-rst req_ready", 64'(req_ready_o), 64'd0);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
